// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 controller: command bytes, FSM states,
// init-step ordering and the DDRAM line-base lookup.
package lcd_pkg;

  localparam logic [7:0] WAKE          = 8'h30;
  localparam logic [7:0] NIB_4BIT      = 8'h20;
  localparam logic [7:0] FUNC_SET_8_2L = 8'h38;
  localparam logic [7:0] FUNC_SET_8_1L = 8'h30;
  localparam logic [7:0] FUNC_SET_4_2L = 8'h28;
  localparam logic [7:0] FUNC_SET_4_1L = 8'h20;
  localparam logic [7:0] DISP_OFF      = 8'h08;
  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] ENTRY_INC     = 8'h06;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] SET_DDRAM     = 8'h80;
  localparam logic [7:0] NEWLINE       = 8'h0A;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_EHIGH,
    S_HOLD,
    S_WAIT
  } lcd_state_e;

  typedef enum logic [3:0] {
    ST_WAKE1,
    ST_WAKE2,
    ST_WAKE3,
    ST_NIB4,
    ST_FUNC,
    ST_DOFF,
    ST_CLEAR,
    ST_ENTRY,
    ST_DON
  } init_step_e;

  // Lines 2 and 3 of a 4-line panel continue lines 0 and 1 in DDRAM.
  function automatic logic [6:0] line_base(input logic [1:0] line, input int cols);
    case (line)
      2'd0:    line_base = 7'h00;
      2'd1:    line_base = 7'h40;
      2'd2:    line_base = 7'(cols);
      default: line_base = 7'(cols + 'h40);
    endcase
  endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Prescaler: one-clk tick every CLK_DIV clocks, counter restarts at 0 on reset.
module lcd_tick_gen #(
  parameter int CLK_DIV = 1024
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character-LCD controller: power-up wait, init sequence, character
// writes with cursor tracking / line wrap, newline and clear, 8- or 4-bit bus.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_DIV     = 1024,
  parameter int BUS_4BIT    = 0,
  parameter int LINES       = 2,
  parameter int COLS        = 16,
  parameter int PWRUP_TICKS = 20,
  parameter int CMD_WAIT    = 1,
  parameter int CLR_WAIT    = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [7:0] wr_char,
  output logic       wr_ready,
  input  logic       clear_req,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam logic [7:0] FUNC_SET = (BUS_4BIT != 0)
    ? ((LINES > 1) ? FUNC_SET_4_2L : FUNC_SET_4_1L)
    : ((LINES > 1) ? FUNC_SET_8_2L : FUNC_SET_8_1L);

  lcd_state_e  state_q, state_d;
  init_step_e  step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        rs_q, rs_d;
  logic        nib_hi_q, nib_hi_d;
  logic        single_q, single_d;
  logic        clr_q, clr_d;
  logic        pend_q, pend_d;
  logic [1:0]  line_q, line_d;
  logic [5:0]  col_q, col_d;
  logic        done_q, done_d;

  logic        tick;
  logic [1:0]  line_nx;
  logic [15:0] wait_len;
  logic [3:0]  nib;

  lcd_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  function automatic logic [7:0] init_byte(input init_step_e s);
    case (s)
      ST_WAKE1, ST_WAKE2, ST_WAKE3: init_byte = WAKE;
      ST_NIB4:  init_byte = NIB_4BIT;
      ST_FUNC:  init_byte = FUNC_SET;
      ST_DOFF:  init_byte = DISP_OFF;
      ST_CLEAR: init_byte = CLEAR;
      ST_ENTRY: init_byte = ENTRY_INC;
      default:  init_byte = DISP_ON;
    endcase
  endfunction

  function automatic init_step_e next_step(input init_step_e s);
    case (s)
      ST_WAKE1: next_step = ST_WAKE2;
      ST_WAKE2: next_step = ST_WAKE3;
      ST_WAKE3: next_step = (BUS_4BIT != 0) ? ST_NIB4 : ST_FUNC;
      ST_NIB4:  next_step = ST_FUNC;
      ST_FUNC:  next_step = ST_DOFF;
      ST_DOFF:  next_step = ST_CLEAR;
      ST_CLEAR: next_step = ST_ENTRY;
      default:  next_step = ST_DON;
    endcase
  endfunction

  assign line_nx  = (line_q == 2'(LINES - 1)) ? 2'd0 : line_q + 2'd1;
  assign wait_len = clr_q ? 16'(CLR_WAIT) : 16'(CMD_WAIT);
  assign nib      = nib_hi_q ? byte_q[7:4] : byte_q[3:0];

  // Handshake: a request (wr_valid or clear_req) is taken on any clk edge where
  // wr_ready=1; clear_req wins and leaves wr_valid pending. SETUP then runs to
  // the next tick, so ready returns after 3+WAIT tick pulses.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    rs_d     = rs_q;
    nib_hi_d = nib_hi_q;
    single_d = single_q;
    clr_d    = clr_q;
    pend_d   = pend_q;
    line_d   = line_q;
    col_d    = col_q;
    done_d   = done_q;
    case (state_q)
      S_PWRUP: if (tick) begin
        if (cnt_q >= 16'(PWRUP_TICKS - 1)) begin
          cnt_d   = '0;
          state_d = S_INIT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_INIT: if (tick) begin
        byte_d   = init_byte(step_q);
        rs_d     = 1'b0;
        clr_d    = (step_q == ST_CLEAR);
        single_d = (BUS_4BIT != 0) && (step_q == ST_WAKE1 || step_q == ST_WAKE2 ||
                                       step_q == ST_WAKE3 || step_q == ST_NIB4);
        nib_hi_d = 1'b1;
        state_d  = S_SETUP;
      end
      S_IDLE: begin
        if (clear_req) begin
          byte_d   = CLEAR;
          rs_d     = 1'b0;
          clr_d    = 1'b1;
          single_d = 1'b0;
          nib_hi_d = 1'b1;
          pend_d   = 1'b0;
          line_d   = 2'd0;
          col_d    = '0;
          state_d  = S_SETUP;
        end else if (wr_valid) begin
          clr_d    = 1'b0;
          single_d = 1'b0;
          nib_hi_d = 1'b1;
          state_d  = S_SETUP;
          if (wr_char == NEWLINE) begin
            byte_d = SET_DDRAM | {1'b0, line_base(line_nx, COLS)};
            rs_d   = 1'b0;
            pend_d = 1'b0;
            line_d = line_nx;
            col_d  = '0;
          end else begin
            byte_d = wr_char;
            rs_d   = 1'b1;
            if (col_q == 6'(COLS - 1)) begin
              pend_d = 1'b1;
              line_d = line_nx;
              col_d  = '0;
            end else begin
              pend_d = 1'b0;
              col_d  = col_q + 6'd1;
            end
          end
        end
      end
      S_SETUP: if (tick) state_d = S_EHIGH;
      S_EHIGH: if (tick) state_d = S_HOLD;
      S_HOLD: if (tick) begin
        if ((BUS_4BIT != 0) && !single_q && nib_hi_q) begin
          nib_hi_d = 1'b0;
          state_d  = S_SETUP;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: if (tick) begin
        if (cnt_q + 16'd1 >= wait_len) begin
          cnt_d = '0;
          if (!done_q) begin
            if (step_q == ST_DON) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              step_d  = next_step(step_q);
              state_d = S_INIT;
            end
          end else if (pend_q) begin
            byte_d   = SET_DDRAM | {1'b0, line_base(line_q, COLS)};
            rs_d     = 1'b0;
            clr_d    = 1'b0;
            single_d = 1'b0;
            nib_hi_d = 1'b1;
            pend_d   = 1'b0;
            state_d  = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_PWRUP;
      step_q   <= ST_WAKE1;
      cnt_q    <= '0;
      byte_q   <= '0;
      rs_q     <= 1'b0;
      nib_hi_q <= 1'b1;
      single_q <= 1'b0;
      clr_q    <= 1'b0;
      pend_q   <= 1'b0;
      line_q   <= '0;
      col_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      rs_q     <= rs_d;
      nib_hi_q <= nib_hi_d;
      single_q <= single_d;
      clr_q    <= clr_d;
      pend_q   <= pend_d;
      line_q   <= line_d;
      col_q    <= col_d;
      done_q   <= done_d;
    end
  end

  assign lcd_e     = (state_q == S_EHIGH);
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_data  = (BUS_4BIT != 0) ? {nib, 4'h0} : byte_q;
  assign wr_ready  = (state_q == S_IDLE);
  assign busy      = ~wr_ready;
  assign init_done = done_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl: an 8-bit and a 4-bit instance, strobe
// monitors feeding per-instance expected queues of {rs, data}.
module tb_lcd_hd44780_ctrl;

  localparam int CLK_DIV = 4;
  localparam int CMD_W   = 1;
  localparam int CLR_W   = 5;

  logic       clk;
  logic       rst8, wr_valid8, clear_req8, wr_ready8, init_done8, busy8, rs8, rw8, e8;
  logic [7:0] wr_char8, data8;
  logic       rst4, wr_valid4, clear_req4, wr_ready4, init_done4, busy4, rs4, rw4, e4;
  logic [7:0] wr_char4, data4;

  logic [8:0] exp8_q[$];
  logic [8:0] exp4_q[$];
  logic       e8_prev, e4_prev;
  int         n_tests, n_fail;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  lcd_hd44780_ctrl #(
    .CLK_DIV(CLK_DIV), .BUS_4BIT(0), .LINES(2), .COLS(16),
    .PWRUP_TICKS(10), .CMD_WAIT(CMD_W), .CLR_WAIT(CLR_W)
  ) dut8 (
    .clk(clk), .reset(rst8), .wr_valid(wr_valid8), .wr_char(wr_char8),
    .wr_ready(wr_ready8), .clear_req(clear_req8), .init_done(init_done8),
    .busy(busy8), .lcd_rs(rs8), .lcd_rw(rw8), .lcd_e(e8), .lcd_data(data8)
  );

  lcd_hd44780_ctrl #(
    .CLK_DIV(CLK_DIV), .BUS_4BIT(1), .LINES(2), .COLS(16),
    .PWRUP_TICKS(10), .CMD_WAIT(CMD_W), .CLR_WAIT(CLR_W)
  ) dut4 (
    .clk(clk), .reset(rst4), .wr_valid(wr_valid4), .wr_char(wr_char4),
    .wr_ready(wr_ready4), .clear_req(clear_req4), .init_done(init_done4),
    .busy(busy4), .lcd_rs(rs4), .lcd_rw(rw4), .lcd_e(e4), .lcd_data(data4)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (e8 && !e8_prev) begin
      check("strobe8_pending", 32'(exp8_q.size() != 0), 32'd1);
      check("strobe8_rw", 32'(rw8), 32'd0);
      if (exp8_q.size() != 0) check("strobe8_byte", 32'({rs8, data8}), 32'(exp8_q.pop_front()));
    end
    e8_prev <= e8;
  end

  always @(negedge clk) begin
    if (e4 && !e4_prev) begin
      check("strobe4_pending", 32'(exp4_q.size() != 0), 32'd1);
      check("strobe4_rw", 32'(rw4), 32'd0);
      check("strobe4_low_nibble", 32'(data4[3:0]), 32'd0);
      if (exp4_q.size() != 0) check("strobe4_byte", 32'({rs4, data4}), 32'(exp4_q.pop_front()));
    end
    e4_prev <= e4;
  end

  // ---------------- driver tasks ----------------
  task automatic push_init8();
    logic [7:0] seq [8];
    seq = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
    for (int i = 0; i < 8; i++) exp8_q.push_back({1'b0, seq[i]});
  endtask

  task automatic push_init4();
    logic [7:0] seq [14];
    seq = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h20, 8'h80, 8'h00, 8'h80,
            8'h00, 8'h10, 8'h00, 8'h60, 8'h00, 8'hC0};
    for (int i = 0; i < 14; i++) exp4_q.push_back({1'b0, seq[i]});
  endtask

  task automatic send8(input logic [7:0] c);
    logic rdy;
    logic ok;
    int   n;
    wr_valid8 = 1'b1;
    wr_char8  = c;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 3000) begin
      rdy = wr_ready8;
      @(posedge clk); #1;
      n++;
      ok = rdy;
    end
    check("send8_accept", 32'(ok), 32'd1);
    wr_valid8 = 1'b0;
    wr_char8  = 8'($urandom_range(0, 255));
  endtask

  task automatic send4(input logic [7:0] c);
    logic rdy;
    logic ok;
    int   n;
    wr_valid4 = 1'b1;
    wr_char4  = c;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 3000) begin
      rdy = wr_ready4;
      @(posedge clk); #1;
      n++;
      ok = rdy;
    end
    check("send4_accept", 32'(ok), 32'd1);
    wr_valid4 = 1'b0;
    wr_char4  = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_ready8(output int n);
    n = 0;
    while (!wr_ready8 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic clear_then_char8(input logic [7:0] c, output int gap);
    logic rdy;
    logic ok;
    int   n;
    clear_req8 = 1'b1;
    wr_valid8  = 1'b1;
    wr_char8   = c;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 3000) begin
      rdy = wr_ready8;
      @(posedge clk); #1;
      n++;
      ok = rdy;
    end
    check("clear8_accept", 32'(ok), 32'd1);
    clear_req8 = 1'b0;
    check("clear8_busy", 32'(busy8), 32'd1);
    ok  = 1'b0;
    gap = 0;
    while (!ok && gap < 3000) begin
      rdy = wr_ready8;
      @(posedge clk); #1;
      gap++;
      ok = rdy;
    end
    wr_valid8 = 1'b0;
  endtask

  task automatic drain8(input string tag);
    int n;
    n = 0;
    while (exp8_q.size() != 0 && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(exp8_q.size()), 32'd0);
  endtask

  task automatic drain4(input string tag);
    int n;
    n = 0;
    while (exp4_q.size() != 0 && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(exp4_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    n_tests = 0;
    n_fail  = 0;
    e8_prev = 1'b0;
    e4_prev = 1'b0;
    rst8 = 1'b1; wr_valid8 = 1'b0; clear_req8 = 1'b0; wr_char8 = 8'h00;
    rst4 = 1'b1; wr_valid4 = 1'b0; clear_req4 = 1'b0; wr_char4 = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    check("rst_e",         32'(e8),         32'd0);
    check("rst_rs",        32'(rs8),        32'd0);
    check("rst_rw",        32'(rw8),        32'd0);
    check("rst_data",      32'(data8),      32'd0);
    check("rst_ready",     32'(wr_ready8),  32'd0);
    check("rst_busy",      32'(busy8),      32'd1);
    check("rst_init_done", 32'(init_done8), 32'd0);
    check("rst4_data",     32'(data4),      32'd0);

    push_init8();
    push_init4();
    rst8 = 1'b0;
    rst4 = 1'b0;

    // 10 power-up ticks of 4 clk: no strobe within the first 40 clk
    n = 0;
    while (!e8 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("pwrup_e_seen", 32'(e8), 32'd1);
    check("pwrup_quiet_over_40", 32'(n > 40), 32'd1);

    // 'A' held valid through init; accepted on the clk after IDLE is entered
    exp8_q.push_back({1'b1, 8'h41});
    send8(8'h41);
    check("init_done8", 32'(init_done8), 32'd1);
    check("accept_ready_drops", 32'(wr_ready8), 32'd0);
    wait_ready8(n);
    check("lat_A_clk", 32'(n), 32'd15);

    // clear and char together: 0x01 first, char accepted after (3+CLR_WAIT) ticks
    exp8_q.push_back({1'b0, 8'h01});
    exp8_q.push_back({1'b1, 8'h5A});
    clear_then_char8(8'h5A, n);
    check("clear_to_char_clk", 32'(n), 32'd32);

    // 'Z' is at (0,0); 15 more fill line 0, then jump to line 1
    for (int i = 0; i < 15; i++) begin
      exp8_q.push_back({1'b1, 8'(8'h61 + i)});
      send8(8'(8'h61 + i));
    end
    exp8_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) begin
      exp8_q.push_back({1'b1, 8'(8'h41 + i)});
      send8(8'(8'h41 + i));
    end
    exp8_q.push_back({1'b0, 8'h80});
    exp8_q.push_back({1'b0, 8'hC0});
    send8(8'h0A);
    exp8_q.push_back({1'b0, 8'h80});
    send8(8'h0A);
    drain8("drain8_chars");

    // reset during EHIGH of a data write, then full init replay
    exp8_q.push_back({1'b1, 8'h42});
    send8(8'h42);
    n = 0;
    while (!(e8 && rs8) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("B_ehigh_seen", 32'(e8 && rs8), 32'd1);
    rst8 = 1'b1;
    @(posedge clk); #1;
    check("abort_e",         32'(e8),         32'd0);
    check("abort_init_done", 32'(init_done8), 32'd0);
    check("abort_ready",     32'(wr_ready8),  32'd0);
    push_init8();
    rst8 = 1'b0;
    n = 0;
    while (!init_done8 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reinit_done8", 32'(init_done8), 32'd1);
    drain8("drain8_reinit");

    // 4-bit instance: init sequence already queued, then one character as two nibbles
    check("init_done4", 32'(init_done4), 32'd1);
    exp4_q.push_back({1'b1, 8'h40});
    exp4_q.push_back({1'b1, 8'h10});
    send4(8'h41);
    drain4("drain4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
